// File: rtl/psram_req_adapter_pkg.sv
// Shared types and constants for the PSRAM request adapter.
//   state_t        : adapter FSM states
//   IP_DATA_W      : PSRAM IP beat width
//   IP_ADDR_W      : PSRAM IP address width (16-bit units)
//   MASK_NONE      : data mask that suppresses every byte of a beat
package psram_req_pkg;
  typedef enum logic [2:0] {
    CALIB,
    IDLE,
    WR_CMD,
    WR_DATA,
    RD_CMD,
    RD_WAIT,
    GAP
  } state_t;

  localparam int IP_DATA_W      = 32;
  localparam int IP_ADDR_W      = 21;
  localparam int PSRAM_ADDR_W   = 22;
  localparam int BYTE_W         = 8;
  localparam int NUM_BYTE_LANES = IP_DATA_W / BYTE_W;
  localparam int LANE_W         = $clog2(NUM_BYTE_LANES);
  localparam logic [NUM_BYTE_LANES-1:0] MASK_NONE = 4'hF;
endpackage

// File: rtl/psram_req_adapter_if.sv
// Mapper <-> adapter single-byte request handshake.
//   master : the memory mapper (issues read/write pulses)
//   slave  : the adapter (returns busy, read byte, timeout pulse)
interface psram_req_adapter_if;
  import psram_req_pkg::*;

  logic                    psram_read;
  logic                    psram_write;
  logic [PSRAM_ADDR_W-1:0] psram_addr;
  logic [BYTE_W-1:0]       psram_din;
  logic [BYTE_W-1:0]       psram_dout;
  logic                    psram_busy;
  logic                    psram_rd_timeout;

  modport master (
    output psram_read, psram_write, psram_addr, psram_din,
    input  psram_dout, psram_busy, psram_rd_timeout
  );

  modport slave (
    input  psram_read, psram_write, psram_addr, psram_din,
    output psram_dout, psram_busy, psram_rd_timeout
  );
endinterface

// File: rtl/psram_lane_sel.sv
// Byte-lane helper: picks the addressed byte out of a beat and builds the
// write mask that enables only that byte.
//   lane      : byte lane within the beat
//   rd_data   : beat, lane i in rd_data[i]
//   rd_byte   : rd_data[lane]
//   lane_mask : 0 on the addressed lane, 1 elsewhere (1 = byte not written)
module psram_lane_sel #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic [LANE_W-1:0]                lane,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]  rd_data,
  output logic [VEC_W-1:0]                 rd_byte,
  output logic [NUM_LANES-1:0]             lane_mask
);
  logic [NUM_LANES-1:0]            hit;
  logic [NUM_LANES-1:0][VEC_W-1:0] masked;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign hit[i]       = (lane == LANE_W'(i));
    assign lane_mask[i] = ~hit[i];
    assign masked[i]    = hit[i] ? rd_data[i] : '0;
  end

  // One-hot select, so an OR of the gated lanes is the mux output.
  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < NUM_LANES; i++) rd_byte = rd_byte | masked[i];
  end
endmodule

// File: rtl/psram_req_adapter.sv
// Converts single-byte mapper requests into burst commands for the Gowin
// PSRAM IP. Writes replicate the byte across the beat and mask all but the
// addressed lane of the addressed beat; reads capture the addressed byte
// from the returned burst. A fixed idle gap follows every burst.
//   clk_78m, bus_reset_n : clock, async active-low reset
//   req                  : mapper handshake (slave side)
//   ip_init_calib        : IP calibration done
//   ip_cmd/ip_cmd_en/ip_addr/ip_wr_data/ip_data_mask : IP command + write beat
//   ip_rd_data/ip_rd_data_valid                      : IP read beats
module psram_req_adapter
  import psram_req_pkg::*;
#(
  parameter int BURST_BEATS = 4,
  parameter int CMD_GAP     = 14,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic                      clk_78m,
  input  logic                      bus_reset_n,
  psram_req_adapter_if.slave        req,
  input  logic                      ip_init_calib,
  output logic                      ip_cmd,
  output logic                      ip_cmd_en,
  output logic [IP_ADDR_W-1:0]      ip_addr,
  output logic [IP_DATA_W-1:0]      ip_wr_data,
  output logic [NUM_BYTE_LANES-1:0] ip_data_mask,
  input  logic [IP_DATA_W-1:0]      ip_rd_data,
  input  logic                      ip_rd_data_valid
);
  localparam int BEAT_W   = $clog2(BURST_BEATS);
  localparam int BEAT_MSB = BEAT_W + 1;
  localparam int TMO_W    = $clog2(RD_TIMEOUT + 1);
  localparam int GAP_W    = $clog2(CMD_GAP + 1);
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
  localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(RD_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(CMD_GAP - 1);
  // Burst alignment in 16-bit units: 2 units per 32-bit beat.
  localparam logic [IP_ADDR_W-1:0] ALIGN     = ~IP_ADDR_W'(2 * BURST_BEATS - 1);

  state_t              state;
  logic                busy_q;
  logic                tmo_q;
  logic [BYTE_W-1:0]   dout_q;
  logic [BEAT_W-1:0]   cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [LANE_W-1:0]   lane_q;
  logic [BEAT_W-1:0]   beat_q;

  logic [LANE_W-1:0]         sel_lane;
  logic [BYTE_W-1:0]         rd_byte;
  logic [NUM_BYTE_LANES-1:0] lane_mask;
  logic [BEAT_W-1:0]         req_beat;
  logic [BEAT_W-1:0]         nxt_beat;

  assign req.psram_busy       = busy_q;
  assign req.psram_dout       = dout_q;
  assign req.psram_rd_timeout = tmo_q;

  // Beat 0's mask is registered on the accept edge, before lane_q is valid,
  // so the lane comes straight from the request while idle.
  assign sel_lane = (state == IDLE) ? req.psram_addr[LANE_W-1:0] : lane_q;
  assign req_beat = req.psram_addr[BEAT_MSB:2];
  assign nxt_beat = cnt + BEAT_W'(1);

  psram_lane_sel #(
    .NUM_LANES (NUM_BYTE_LANES),
    .VEC_W     (BYTE_W)
  ) u_lane_sel (
    .lane      (sel_lane),
    .rd_data   (ip_rd_data),
    .rd_byte   (rd_byte),
    .lane_mask (lane_mask)
  );

  always_ff @(posedge clk_78m or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      state        <= CALIB;
      busy_q       <= 1'b1;
      tmo_q        <= 1'b0;
      dout_q       <= '0;
      ip_cmd       <= 1'b0;
      ip_cmd_en    <= 1'b0;
      ip_addr      <= '0;
      ip_wr_data   <= '0;
      ip_data_mask <= MASK_NONE;
      cnt          <= '0;
      tmo_cnt      <= '0;
      gap_cnt      <= '0;
      lane_q       <= '0;
      beat_q       <= '0;
    end else begin
      ip_cmd_en <= 1'b0;
      tmo_q     <= 1'b0;
      case (state)
        CALIB: begin
          if (ip_init_calib) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        IDLE: begin
          if (!ip_init_calib) begin
            state  <= CALIB;
            busy_q <= 1'b1;
          end else if (req.psram_write || req.psram_read) begin
            busy_q    <= 1'b1;
            ip_cmd_en <= 1'b1;
            ip_addr   <= req.psram_addr[PSRAM_ADDR_W-1:1] & ALIGN;
            lane_q    <= req.psram_addr[LANE_W-1:0];
            beat_q    <= req_beat;
            cnt       <= '0;
            if (req.psram_write) begin
              state        <= WR_CMD;
              ip_cmd       <= 1'b1;
              ip_wr_data   <= {NUM_BYTE_LANES{req.psram_din}};
              ip_data_mask <= (req_beat == '0) ? lane_mask : MASK_NONE;
            end else begin
              state   <= RD_CMD;
              ip_cmd  <= 1'b0;
              tmo_cnt <= '0;
            end
          end
        end
        WR_CMD, WR_DATA: begin
          if (state == WR_DATA && cnt == LAST_BEAT) begin
            state        <= GAP;
            gap_cnt      <= '0;
            ip_data_mask <= MASK_NONE;
          end else begin
            state        <= WR_DATA;
            cnt          <= nxt_beat;
            ip_data_mask <= (nxt_beat == beat_q) ? lane_mask : MASK_NONE;
          end
        end
        RD_CMD: begin
          state   <= RD_WAIT;
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        RD_WAIT: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (ip_rd_data_valid) begin
            cnt <= nxt_beat;
            if (cnt == beat_q) dout_q <= rd_byte;
          end
          // A last beat arriving on the final allowed cycle still completes.
          if (ip_rd_data_valid && cnt == LAST_BEAT) begin
            state   <= GAP;
            gap_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= GAP;
            gap_cnt <= '0;
            tmo_q   <= 1'b1;
          end
        end
        GAP: begin
          if (!ip_init_calib) begin
            state <= CALIB;
          end else if (gap_cnt == GAP_LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state  <= CALIB;
          busy_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_psram_req_adapter.sv
module tb_psram_req_adapter;
  import psram_req_pkg::*;

  logic        clk_78m = 1'b0;
  logic        bus_reset_n = 1'b0;
  logic        ip_init_calib = 1'b0;
  logic        ip_cmd, ip_cmd_en;
  logic [20:0] ip_addr;
  logic [31:0] ip_wr_data;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_rd_data = '0;
  logic        ip_rd_data_valid = 1'b0;

  psram_req_adapter_if bus();

  psram_req_adapter #(.BURST_BEATS(4), .CMD_GAP(14), .RD_TIMEOUT(255)) dut (
    .clk_78m          (clk_78m),
    .bus_reset_n      (bus_reset_n),
    .req              (bus),
    .ip_init_calib    (ip_init_calib),
    .ip_cmd           (ip_cmd),
    .ip_cmd_en        (ip_cmd_en),
    .ip_addr          (ip_addr),
    .ip_wr_data       (ip_wr_data),
    .ip_data_mask     (ip_data_mask),
    .ip_rd_data       (ip_rd_data),
    .ip_rd_data_valid (ip_rd_data_valid)
  );

  always #5 clk_78m = ~clk_78m;

  int errors = 0;
  int checks = 0;
  int cmd_en_cnt = 0;

  typedef struct {
    logic        rd;        // also raise psram_read on the request cycle
    logic        poke;      // stray psram_write while busy
    logic [21:0] addr;
    logic [7:0]  din;
    logic [20:0] exp_addr;
    logic [3:0][3:0] exp_mask;  // [beat]
  } wvec_t;

  typedef struct {
    logic [21:0] addr;
    int          lat;       // cycles from command to first valid
    logic [20:0] exp_addr;
    logic [7:0]  exp_dout;
  } rvec_t;

  wvec_t wv[4];
  rvec_t rv[4];
  logic [31:0] beat_data[4];
  logic [7:0]  last_dout;

  task automatic tick();
    @(posedge clk_78m);
    #1;
    if (ip_cmd_en) cmd_en_cnt++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    beat_data[0] = 32'h11223344;
    beat_data[1] = 32'h22334455;
    beat_data[2] = 32'h33445566;
    beat_data[3] = 32'h44556677;

    wv[0] = '{rd:1'b0, poke:1'b1, addr:22'h012345, din:8'hA5, exp_addr:21'h0091A0, exp_mask:16'hFFDF};
    wv[1] = '{rd:1'b0, poke:1'b0, addr:22'h000000, din:8'h3C, exp_addr:21'h000000, exp_mask:16'hFFFE};
    wv[2] = '{rd:1'b0, poke:1'b0, addr:22'h3FFFFF, din:8'hFF, exp_addr:21'h1FFFF8, exp_mask:16'h7FFF};
    wv[3] = '{rd:1'b1, poke:1'b0, addr:22'h00000A, din:8'h5A, exp_addr:21'h000000, exp_mask:16'hFBFF};

    rv[0] = '{addr:22'h00000E, lat:3, exp_addr:21'h000000, exp_dout:8'h55};
    rv[1] = '{addr:22'h000000, lat:1, exp_addr:21'h000000, exp_dout:8'h44};
    rv[2] = '{addr:22'h000107, lat:5, exp_addr:21'h000080, exp_dout:8'h22};
    rv[3] = '{addr:22'h2ABCDB, lat:2, exp_addr:21'h155E68, exp_dout:8'h33};

    bus.psram_read = 1'b0;
    bus.psram_write = 1'b0;
    bus.psram_addr = '0;
    bus.psram_din = '0;

    // Reset values
    repeat (3) tick();
    chk("rst busy", 32'(bus.psram_busy), 32'd1);
    chk("rst dout", 32'(bus.psram_dout), 32'h00);
    chk("rst rd_timeout", 32'(bus.psram_rd_timeout), 32'd0);
    chk("rst cmd_en", 32'(ip_cmd_en), 32'd0);
    chk("rst cmd", 32'(ip_cmd), 32'd0);
    chk("rst ip_addr", 32'(ip_addr), 32'd0);
    chk("rst wr_data", ip_wr_data, 32'd0);
    chk("rst mask", 32'(ip_data_mask), 32'hF);

    // Calibration: requests and valids ignored until calib, busy drops after
    bus_reset_n = 1'b1;
    cmd_en_cnt = 0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      tick();
      ip_rd_data_valid = (cyc == 5);
      ip_rd_data = (cyc == 5) ? 32'hFFFFFFFF : 32'h0;
      bus.psram_read = (cyc == 10);
      if (cyc == 20) begin
        chk("calib busy c20", 32'(bus.psram_busy), 32'd1);
        ip_init_calib = 1'b1;
      end
      if (cyc == 22) chk("calib busy c22", 32'(bus.psram_busy), 32'd0);
    end
    chk("calib no cmd_en", 32'(cmd_en_cnt), 32'd0);
    chk("calib dout", 32'(bus.psram_dout), 32'h00);

    // Write table
    for (int i = 0; i < 4; i++) begin
      cmd_en_cnt = 0;
      bus.psram_write = 1'b1;
      bus.psram_read = wv[i].rd;
      bus.psram_addr = wv[i].addr;
      bus.psram_din = wv[i].din;
      tick();
      bus.psram_write = 1'b0;
      bus.psram_read = 1'b0;
      chk($sformatf("wr%0d cmd_en", i), 32'(ip_cmd_en), 32'd1);
      chk($sformatf("wr%0d cmd", i), 32'(ip_cmd), 32'd1);
      chk($sformatf("wr%0d ip_addr", i), 32'(ip_addr), 32'(wv[i].exp_addr));
      chk($sformatf("wr%0d data", i), ip_wr_data, {4{wv[i].din}});
      chk($sformatf("wr%0d mask b0", i), 32'(ip_data_mask), 32'(wv[i].exp_mask[0]));
      for (int b = 1; b < 4; b++) begin
        tick();
        bus.psram_write = 1'b0;
        chk($sformatf("wr%0d mask b%0d", i, b), 32'(ip_data_mask), 32'(wv[i].exp_mask[b]));
        chk($sformatf("wr%0d data b%0d", i, b), ip_wr_data, {4{wv[i].din}});
        if (wv[i].poke && b == 1) begin
          bus.psram_write = 1'b1;
          bus.psram_addr = 22'h3FFFFC;
          bus.psram_din = 8'h00;
        end
      end
      n = 4;
      while (bus.psram_busy && n < 100) begin
        tick();
        n++;
      end
      chk($sformatf("wr%0d busy latency", i), 32'(n), 32'd19);
      chk($sformatf("wr%0d cmd_en count", i), 32'(cmd_en_cnt), 32'd1);
      chk($sformatf("wr%0d ip_addr hold", i), 32'(ip_addr), 32'(wv[i].exp_addr));
    end

    // Read table
    for (int i = 0; i < 4; i++) begin
      cmd_en_cnt = 0;
      bus.psram_read = 1'b1;
      bus.psram_addr = rv[i].addr;
      tick();
      bus.psram_read = 1'b0;
      chk($sformatf("rd%0d cmd_en", i), 32'(ip_cmd_en), 32'd1);
      chk($sformatf("rd%0d cmd", i), 32'(ip_cmd), 32'd0);
      chk($sformatf("rd%0d ip_addr", i), 32'(ip_addr), 32'(rv[i].exp_addr));
      for (int k = 1; k <= rv[i].lat + 3; k++) begin
        tick();
        ip_rd_data_valid = (k >= rv[i].lat);
        ip_rd_data = (k >= rv[i].lat) ? beat_data[k - rv[i].lat] : 32'h0;
      end
      tick();
      ip_rd_data_valid = 1'b0;
      ip_rd_data = '0;
      chk($sformatf("rd%0d dout", i), 32'(bus.psram_dout), 32'(rv[i].exp_dout));
      n = 1;
      while (bus.psram_busy && n < 100) begin
        tick();
        n++;
      end
      chk($sformatf("rd%0d busy after last valid", i), 32'(n), 32'd15);
      chk($sformatf("rd%0d cmd_en count", i), 32'(cmd_en_cnt), 32'd1);
      last_dout = rv[i].exp_dout;
    end

    // Read timeout
    bus.psram_read = 1'b1;
    bus.psram_addr = 22'h00000E;
    tick();
    bus.psram_read = 1'b0;
    n = 0;
    while (!bus.psram_rd_timeout && n < 400) begin
      tick();
      n++;
    end
    chk("tmo pulse cycle", 32'(n), 32'd255);
    chk("tmo dout held", 32'(bus.psram_dout), 32'(last_dout));
    tick();
    chk("tmo pulse width", 32'(bus.psram_rd_timeout), 32'd0);
    n = 1;
    while (bus.psram_busy && n < 100) begin
      tick();
      n++;
    end
    chk("tmo busy gap", 32'(n), 32'd14);

    // Reset mid-burst during beat 1
    bus.psram_read = 1'b1;
    bus.psram_addr = 22'h00000E;
    tick();
    bus.psram_read = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      ip_rd_data_valid = (k >= 2);
      ip_rd_data = (k >= 2) ? beat_data[k - 2] : 32'h0;
    end
    bus_reset_n = 1'b0;
    #1;
    chk("mid rst cmd_en", 32'(ip_cmd_en), 32'd0);
    chk("mid rst busy", 32'(bus.psram_busy), 32'd1);
    chk("mid rst dout", 32'(bus.psram_dout), 32'h00);
    ip_rd_data_valid = 1'b0;
    tick();
    tick();
    bus_reset_n = 1'b1;
    cmd_en_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      ip_rd_data_valid = 1'b1;
      ip_rd_data = beat_data[3];
      tick();
    end
    ip_rd_data_valid = 1'b0;
    chk("post rst dout", 32'(bus.psram_dout), 32'h00);
    chk("post rst cmd_en count", 32'(cmd_en_cnt), 32'd0);
    chk("post rst busy", 32'(bus.psram_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
